// File: rtl/ctrl_pipeline.sv
// Control-signal pipeline for a 5-stage core: carries decode-stage control
// bundles through ID/EX, EX/MEM and MEM/WB, detects load-use hazards, and
// resolves branches/jumps in EX.
// Optional build macro: CTRL_PIPE_PERF_EN adds saturating stall/flush counters.
module ctrl_pipeline (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] WB_in,
    input  logic [1:0] M_in,
    input  logic [3:0] EX_in,
    input  logic       Jmp_in,
    input  logic       Branch_in,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic [4:0] rd_id,
    input  logic       zero_ex,
    output logic [3:0] EX_out,
    output logic [4:0] dest_ex_out,
    output logic [1:0] M_out,
    output logic [1:0] WB_out,
    output logic [4:0] dest_wb_out,
    output logic       stall_out,
    output logic       pc_src_out,
    output logic       jmp_out,
    output logic       flush_out
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [15:0] stall_cnt_out,
    output logic [15:0] flush_cnt_out
`endif
);

    typedef struct packed {
        logic [1:0] wb;
        logic [1:0] m;
        logic [3:0] ex;
        logic       jmp;
        logic       branch;
        logic [4:0] dest;
    } id_ex_t;

    typedef struct packed {
        logic [1:0] wb;
        logic [1:0] m;
        logic [4:0] dest;
    } ex_mem_t;

    typedef struct packed {
        logic [1:0] wb;
        logic [4:0] dest;
    } mem_wb_t;

    id_ex_t  id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    logic    load_use;
    logic    redirect;
    logic    kill_id;
    id_ex_t  id_bundle;

    // Hazard detection and branch resolution from the EX-stage bundle.
    always_comb begin
        load_use  = id_ex.m[1] && (id_ex.dest != 5'd0) &&
                    ((id_ex.dest == rs_id) || (id_ex.dest == rt_id));
        redirect  = id_ex.branch & (id_ex.jmp | zero_ex);
        kill_id   = load_use | redirect;
        id_bundle = '0;
        id_bundle.wb     = WB_in;
        id_bundle.m      = M_in;
        id_bundle.ex     = EX_in;
        id_bundle.jmp    = Jmp_in;
        id_bundle.branch = Branch_in;
        id_bundle.dest   = EX_in[3] ? rd_id : rt_id;
    end

    // ID/EX capture; a stall or flush replaces the decode bundle with a bubble.
    always_ff @(posedge clk) begin
        if (rst || kill_id)
            id_ex <= '0;
        else
            id_ex <= id_bundle;
    end

    // EX/MEM and MEM/WB always advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            ex_mem <= '{wb: id_ex.wb, m: id_ex.m, dest: id_ex.dest};
            mem_wb <= '{wb: ex_mem.wb, dest: ex_mem.dest};
        end
    end

    // Output mapping; a write to register zero is suppressed at WB.
    always_comb begin
        EX_out      = id_ex.ex;
        dest_ex_out = id_ex.dest;
        M_out       = ex_mem.m;
        WB_out      = {mem_wb.wb[1] & (mem_wb.dest != 5'd0), mem_wb.wb[0]};
        dest_wb_out = mem_wb.dest;
        pc_src_out  = redirect;
        jmp_out     = id_ex.jmp & redirect;
        flush_out   = redirect;
        // Flush wins: the stalled instruction is being discarded anyway.
        stall_out   = load_use & ~redirect;
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_out && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (flush_out && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign stall_cnt_out = stall_cnt;
    assign flush_cnt_out = flush_cnt;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline with a per-stage expectation scoreboard.
// Build with CTRL_PIPE_PERF_EN defined to also check the event counters.
module tb_ctrl_pipeline;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] WB_in, M_in;
    logic [3:0] EX_in;
    logic       Jmp_in, Branch_in;
    logic [4:0] rs_id, rt_id, rd_id;
    logic       zero_ex;
    logic [3:0] EX_out;
    logic [4:0] dest_ex_out;
    logic [1:0] M_out;
    logic [1:0] WB_out;
    logic [4:0] dest_wb_out;
    logic       stall_out, pc_src_out, jmp_out, flush_out;
`ifdef CTRL_PIPE_PERF_EN
    logic [15:0] stall_cnt_out, flush_cnt_out;
`endif

    ctrl_pipeline dut (
        .clk(clk), .rst(rst),
        .WB_in(WB_in), .M_in(M_in), .EX_in(EX_in),
        .Jmp_in(Jmp_in), .Branch_in(Branch_in),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .zero_ex(zero_ex),
        .EX_out(EX_out), .dest_ex_out(dest_ex_out),
        .M_out(M_out), .WB_out(WB_out), .dest_wb_out(dest_wb_out),
        .stall_out(stall_out), .pc_src_out(pc_src_out),
        .jmp_out(jmp_out), .flush_out(flush_out)
`ifdef CTRL_PIPE_PERF_EN
        , .stall_cnt_out(stall_cnt_out), .flush_cnt_out(flush_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] wb;
        logic [1:0] m;
        logic [3:0] ex;
        logic [4:0] dest;
    } bundle_t;

    bundle_t q_ex[$];
    bundle_t q_m[$];
    bundle_t q_wb[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_stall_exp = 0;
    int n_flush_exp = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic queue_empty_fail(input string tag);
        n_cmp++;
        n_fail++;
        $error("FAIL %s: observed empty scoreboard expected entry", tag);
    endtask

    // Called #1 after each rising edge: compare every stage with its queued expectation.
    task automatic stage_check();
        bundle_t w, m, e;
        if (q_wb.size() == 0) begin queue_empty_fail("wb_q"); w = '0; end
        else w = q_wb.pop_front();
        check("wb_out", WB_out, {w.wb[1] & (w.dest != 5'd0), w.wb[0]});
        check("dest_wb", dest_wb_out, w.dest);
        if (q_m.size() == 0) begin queue_empty_fail("m_q"); m = '0; end
        else m = q_m.pop_front();
        check("m_out", M_out, m.m);
        q_wb.push_back(m);
        if (q_ex.size() == 0) begin queue_empty_fail("ex_q"); e = '0; end
        else e = q_ex.pop_front();
        check("ex_out", EX_out, e.ex);
        check("dest_ex", dest_ex_out, e.dest);
        q_m.push_back(e);
    endtask

    task automatic step(input logic [1:0] wb, input logic [1:0] m, input logic [3:0] ex,
                        input logic jmp, input logic br,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic zero,
                        input logic e_stall, input logic e_flush, input logic e_jmp);
        bundle_t b;
        WB_in = wb; M_in = m; EX_in = ex; Jmp_in = jmp; Branch_in = br;
        rs_id = rs; rt_id = rt; rd_id = rd; zero_ex = zero;
        #1;
        check("stall", stall_out, e_stall);
        check("pc_src", pc_src_out, e_flush);
        check("flush", flush_out, e_flush);
        check("jmp", jmp_out, e_jmp);
        if (e_stall) n_stall_exp++;
        if (e_flush) n_flush_exp++;
        b.wb = wb; b.m = m; b.ex = ex; b.dest = ex[3] ? rd : rt;
        if (e_stall || e_flush) b = '0;
        q_ex.push_back(b);
        @(posedge clk); #1;
        stage_check();
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++)
            step(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ex", EX_out, 4'd0);
        check("rst_dest_ex", dest_ex_out, 5'd0);
        check("rst_m", M_out, 2'd0);
        check("rst_wb", WB_out, 2'd0);
        check("rst_dest_wb", dest_wb_out, 5'd0);
        check("rst_stall", stall_out, 1'b0);
        check("rst_pc_src", pc_src_out, 1'b0);
        check("rst_jmp", jmp_out, 1'b0);
        check("rst_flush", flush_out, 1'b0);
`ifdef CTRL_PIPE_PERF_EN
        check("rst_stall_cnt", stall_cnt_out, 16'd0);
        check("rst_flush_cnt", flush_cnt_out, 16'd0);
        n_stall_exp = 0;
        n_flush_exp = 0;
`endif
        rst = 1'b0;
        q_ex.delete(); q_m.delete(); q_wb.delete();
        q_m.push_back('0);
        q_wb.push_back('0);
    endtask

    task automatic check_counters();
`ifdef CTRL_PIPE_PERF_EN
        check("stall_cnt", stall_cnt_out, n_stall_exp[15:0]);
        check("flush_cnt", flush_cnt_out, n_flush_exp[15:0]);
`endif
    endtask

    initial begin
        rst = 1'b1;
        WB_in = '0; M_in = '0; EX_in = '0; Jmp_in = 1'b0; Branch_in = 1'b0;
        rs_id = '0; rt_id = '0; rd_id = '0; zero_ex = 1'b0;
        do_reset();

        // R-type, rd=5: EX at +1, WB at +3
        step(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(3);

        // Load-use: lw r8, then add using r8 (held in ID across the stall)
        step(2'b11, 2'b10, 4'b0001, 1'b0, 1'b0, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd8, 5'd9, 5'd10, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(3);

        // Load to r0 never stalls
        step(2'b11, 2'b10, 4'b0001, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd0, 5'd0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(3);

        // beq taken: next decode bundle is flushed
        step(2'b00, 2'b00, 4'b0010, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd3, 5'd4, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
        nop(3);

        // beq not taken: next bundle proceeds
        step(2'b00, 2'b00, 4'b0010, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd3, 5'd4, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(3);

        // Jump with zero_ex=0 and with zero_ex=1
        step(2'b00, 2'b00, 4'b0000, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd3, 5'd4, 5'd14, 1'b0, 1'b0, 1'b1, 1'b1);
        step(2'b00, 2'b00, 4'b0000, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd3, 5'd4, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1);
        nop(3);

        // Flush and load-use in the same cycle: flush wins, no stall
        step(2'b00, 2'b10, 4'b0010, 1'b0, 1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd8, 5'd9, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0);
        nop(3);

        // ADDI to r0: RegWrite suppressed at WB
        step(2'b10, 2'b00, 4'b0001, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(3);
        check_counters();

        // Mid-stream reset with three bundles in flight
        step(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd1, 5'd2, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b11, 2'b10, 4'b0001, 1'b0, 1'b0, 5'd1, 5'd21, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 2'b01, 4'b0001, 1'b0, 1'b0, 5'd3, 5'd22, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        WB_in = 2'b11; M_in = 2'b10; EX_in = 4'b1100; rd_id = 5'd23;
        do_reset();

        // Recovery after reset
        step(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(3);
        check_counters();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port WB_in, input, 2, decode-stage {RegWrite, MemToReg}.
REQ-004 SHALL have port M_in, input, 2, decode-stage {MemRead, MemWrite}.
REQ-005 SHALL have port EX_in, input, 4, decode-stage {RegDst, ALUOp[1:0], ALUSrc}.
REQ-006 SHALL have port Jmp_in / Branch_in, input, 1 each, decode-stage jump/branch flags.
REQ-007 SHALL have ports rs_id / rt_id / rd_id, input, 5 each, decode-stage register fields.
REQ-008 SHALL have port zero_ex, input, 1, ALU zero flag of the instruction in EX.
REQ-009 SHALL have port EX_out, output, 4, EX-stage copy of EX_in.
REQ-010 SHALL have port dest_ex_out, output, 5, EX-stage destination register.
REQ-011 SHALL have port M_out, output, 2, MEM-stage copy of M_in.
REQ-012 SHALL have port WB_out, output, 2, WB-stage copy of WB_in.
REQ-013 SHALL have port dest_wb_out, output, 5, WB-stage destination register.
REQ-014 SHALL have port stall_out, output, 1, hold PC and IF/ID this cycle.
REQ-015 SHALL have port pc_src_out / jmp_out, output, 1 each, redirect fetch / redirect is a jump.
REQ-016 SHALL have port flush_out, output, 1, clear IF/ID this cycle.

Function
REQ-017 SHALL hold three register stages, ID/EX, EX/MEM and MEM/WB; an all-zero stage is a bubble.
REQ-018 SHALL capture a bundle into ID/EX every cycle unless REQ-022 or REQ-021 applies; latency to EX_out is 1 cycle, to M_out 2 cycles, to WB_out 3 cycles.
REQ-019 SHALL select the destination register at ID/EX capture: dest = RegDst ? rd_id : rt_id; the destination travels with the bundle.
REQ-020 SHALL force WB_out[1] (RegWrite) to 0 whenever dest_wb_out == 0.
REQ-021 SHALL assert stall_out combinationally when MemRead_ex = 1, dest_ex != 0 and dest_ex equals rs_id or rt_id.
- On stall: ID/EX loads a bubble.
- EX/MEM and MEM/WB advance normally.
- A stall lasts exactly one cycle per load-use pair.
REQ-022 SHALL drive pc_src_out = Branch_ex & (Jmp_ex | zero_ex) and jmp_out = Jmp_ex & pc_src_out.
- flush_out = pc_src_out.
- On flush: ID/EX loads a bubble.
REQ-023 SHALL give flush priority over stall when both conditions hold in the same cycle; stall_out is 0 that cycle.
REQ-024 SHALL advance EX/MEM and MEM/WB unconditionally; a bubble inserted in ID/EX propagates as a bubble.

Reset
REQ-025 SHALL clear all stage registers to bubbles on rst = 1 at a clock edge; all outputs are 0 the following cycle.
REQ-026 SHALL discard in-flight bundles on mid-operation reset; rst has priority over stall and flush.

Configuration
REQ-027 SHALL, when CTRL_PIPE_PERF_EN is defined, add outputs stall_cnt_out[15:0] and flush_cnt_out[15:0].
- Each counter increments once per cycle its event is asserted.
- Each counter saturates at 16'hFFFF.
- Both counters are cleared by rst.
REQ-028 SHALL, without CTRL_PIPE_PERF_EN, have neither counter port nor counter logic.

Verification
REQ-029 SHALL cover the R-type path: WB_in=2'b10, M_in=0, EX_in=4'b1100, rd_id=5 at cycle 0 -> EX_out=4'b1100 and dest_ex_out=5 at cycle 1; WB_out=2'b10 and dest_wb_out=5 at cycle 3.
REQ-030 SHALL cover load-use: lw (M_in=2'b10, rt_id=8), then an instruction with rs_id=8 -> stall_out=1 for exactly one cycle, then one bubble in EX_out.
REQ-031 SHALL cover a branch: beq in EX with zero_ex=1 -> pc_src_out=1, flush_out=1 and jmp_out=0; the next EX_out is a bubble. With zero_ex=0 -> no flush.
REQ-032 SHALL cover a jump: Branch_in=1, Jmp_in=1 -> in EX, pc_src_out=1 and jmp_out=1 regardless of zero_ex.
REQ-033 SHALL cover the zero destination: ADDI with rt_id=0 -> WB_out[1]=0 at WB.
REQ-034 SHALL cover reset: rst=1 mid-stream with three valid bundles in flight -> all outputs 0 the next cycle; with CTRL_PIPE_PERF_EN, counters read 0.
